// File: rtl/dmi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dmi_pkg
//  Description : Shared types and constants for the DMI initiator. Defines the
//                DTM command opcodes, the sticky DMI status codes, the
//                initiator state encoding and the debug module register map.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;

    // Debug module register addresses
    localparam logic [DMI_ADDR_W-1:0] DMCONTROL   = 7'h10;
    localparam logic [DMI_ADDR_W-1:0] HAWINDOWSEL = 7'h14;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        SUCCESS = 2'd0,
        FAILED  = 2'd2,
        BUSY    = 2'd3
    } dmi_status_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } dmi_state_e;

    // True for the two opcodes that start a DMI access.
    function automatic logic is_access(input logic [1:0] op);
        return (op == READ) || (op == WRITE);
    endfunction

endpackage : dmi_pkg
`default_nettype wire

// File: rtl/dmi_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_timeout_ctr
//  Description : Response timeout counter for the DMI initiator. Cleared when
//                a request is accepted, counts while enabled and flags expiry
//                once the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
//  Revision    : 1.0 - initial release
//  Ports       : clock      - clock
//                reset      - asynchronous active-high reset
//                clr_i      - synchronous clear (request accepted)
//                en_i       - count enable (waiting for a response)
//                expired_o  - count has reached TIMEOUT-1
// ============================================================================
module dmi_timeout_ctr #(
    parameter int TIMEOUT = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused  = clock ^ reset ^ clr_i ^ en_i;
            assign expired_o = 1'b0;
        end else begin : g_enabled
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= '0;
                end else if (en_i && (cnt_q != LAST)) begin
                    // Saturate at LAST so the flag cannot wrap back to zero.
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign expired_o = (cnt_q == LAST);
        end
    endgenerate

endmodule : dmi_timeout_ctr
`default_nettype wire

// File: rtl/dmi_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_initiator
//  Description : DTM-side DMI master. Takes one read/write command at a time,
//                issues it on the DMI request channel, collects the response
//                and keeps a sticky two-bit status (success/failed/busy).
//  Revision    : 1.0 - initial release
//  Ports       : clock, reset            - clock, async active-high reset
//                cmd_valid/op/addr/data  - DTM command (single-cycle strobe)
//                dmi_reset               - clear sticky status
//                dmi_hard_reset          - abort operation and clear status
//                req_*                   - DMI request channel (initiator)
//                resp_*                  - DMI response channel
//                rd_data                 - last captured read data
//                status                  - 0 success, 2 failed, 3 busy
//                idle                    - no operation in progress
//                done                    - one-cycle completion pulse
// ============================================================================
module dmi_initiator
    import dmi_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int ADDR_W  = DMI_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [31:0]       req_data,
    output logic [3:0]        req_mask,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [31:0]       resp_data,
    input  logic              resp_err,
    output logic [31:0]       rd_data,
    output logic [1:0]        status,
    output logic              idle,
    output logic              done
);

    dmi_state_e        state_q,   state_d;
    logic              write_q,   write_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [1:0]        status_q,  status_d;
    logic              done_q,    done_d;

    logic w_cmd_access;
    logic w_accept;
    logic w_expired;
    logic w_set_fail;
    logic w_set_busy;

    assign w_cmd_access = cmd_valid && is_access(cmd_op);
    // A hard reset in the handshake cycle cancels the acceptance.
    assign w_accept     = (state_q == ST_REQ) && req_ready && !dmi_hard_reset;

    dmi_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (w_accept),
        .en_i      (state_q == ST_WAIT),
        .expired_o (w_expired)
    );

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        status_d   = status_q;
        done_d     = 1'b0;
        w_set_fail = 1'b0;
        w_set_busy = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!dmi_hard_reset && w_cmd_access && (status_q == SUCCESS)) begin
                    state_d = ST_REQ;
                    write_d = (cmd_op == WRITE);
                    addr_d  = cmd_addr;
                    wdata_d = cmd_data;
                end
            end
            ST_REQ: begin
                if (dmi_hard_reset) begin
                    state_d = ST_IDLE;
                end else if (req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmi_hard_reset) begin
                    // A response arriving with the abort is consumed here,
                    // otherwise DRAIN would wait for one that never comes.
                    state_d = resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (resp_valid) begin
                    if (!write_q) begin
                        rd_data_d = resp_data;
                    end
                    w_set_fail = resp_err;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else if (w_expired) begin
                    w_set_fail = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && w_cmd_access) begin
            w_set_busy = 1'b1;
        end

        // Sticky status: only the first error is recorded; clears win.
        if (status_q == SUCCESS) begin
            if (w_set_fail) begin
                status_d = FAILED;
            end else if (w_set_busy) begin
                status_d = BUSY;
            end
        end
        if (dmi_reset || dmi_hard_reset) begin
            status_d = SUCCESS;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            status_q  <= SUCCESS;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            status_q  <= status_d;
            done_q    <= done_d;
        end
    end

    assign req_valid  = (state_q == ST_REQ);
    assign resp_ready = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign req_write  = write_q;
    assign req_addr   = addr_q;
    assign req_data   = wdata_q;
    assign req_mask   = 4'hf;
    assign rd_data    = rd_data_q;
    assign status     = status_q;
    assign done       = done_q;
    // The completion cycle is reported by done; idle follows one cycle later.
    assign idle       = (state_q == ST_IDLE) && !done_q;

endmodule : dmi_initiator
`default_nettype wire

// File: doc/dmi_initiator.md
# dmi_initiator

Debug-transport-side master for the Debug Module Interface (DMI). It accepts one read or write command at a time from the JTAG DTM shift logic and issues it as a DMI request to the debug module register file, which holds dmcontrol, hawindowsel and the halt-request mask. It then collects the response and reports a sticky two-bit DMI status in the RISC-V debug-spec style: success, failed, or busy. It sits between the DTM `dmi` data register and the DM register block, and is the initiator for that block's request/response interface.

## Interface
- `TIMEOUT`, default 1023: cycles to wait for a response after the request is accepted. 0 disables the timeout.
- `ADDR_W`, default 7: DMI address width.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  DTM command strobe, single cycle.
- `cmd_op`  in  2  0 nop, 1 read, 2 write, 3 reserved.
- `cmd_addr`  in  ADDR_W  register address.
- `cmd_data`  in  32  write data.
- `dmi_reset`  in  1  clears the sticky status.
- `dmi_hard_reset`  in  1  aborts any outstanding operation and clears the status.
- `req_valid`  out  1  DMI request valid.
- `req_ready`  in  1  DMI request ready.
- `req_write`  out  1  1 = write, 0 = read.
- `req_addr`  out  ADDR_W  request address.
- `req_data`  out  32  request write data.
- `req_mask`  out  4  byte mask, always 4'hf.
- `resp_valid`  in  1  response valid.
- `resp_ready`  out  1  response ready.
- `resp_data`  in  32  read data.
- `resp_err`  in  1  response error.
- `rd_data`  out  32  last captured read data.
- `status`  out  2  0 success, 2 failed, 3 busy.
- `idle`  out  1  state is IDLE.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
States: IDLE, REQ, WAIT, DRAIN.
- **IDLE**
  - A `cmd_valid` with op 1 or 2, while `status`==0, latches op, addr and data and moves to REQ.
  - Op 0 or 3 is ignored.
  - Any command while `status`!=0 is ignored.
- **REQ**
  - `req_valid`=1 with the latched fields held stable.
  - On `req_valid&req_ready`, go to WAIT and clear the timeout counter.
- **WAIT**
  - `resp_ready`=1 and the counter increments.
  - On `resp_valid`:
    - a read captures `resp_data` into `rd_data`;
    - `resp_err` sets `status`=2;
    - `done` pulses; go to IDLE.
  - If the counter reaches TIMEOUT-1 with no response: `status`=2, `done` pulses, go to DRAIN.
- **DRAIN**
  - `resp_ready`=1; the next response is discarded.
  - Go to IDLE on `resp_valid`.
- **Busy:** `cmd_valid` with op 1 or 2 in REQ, WAIT or DRAIN sets `status`=3 if `status` is 0. The command is dropped and the in-flight operation is unaffected.
- **Status priority:** the first error wins. Once non-zero, `status` holds until `dmi_reset` or `dmi_hard_reset`.
- **`dmi_reset`:** clears `status` only; it does not change state. If it coincides with an error-setting event, the clear wins.
- **`dmi_hard_reset`:**
  - From REQ: go to IDLE. `req_valid` drops next cycle and any handshake in that same cycle is ignored.
  - From WAIT: go to DRAIN.
  - Clears `status` in all states.
  - No `done` pulse.
- **Writes:** `rd_data` is unchanged by writes and by discarded responses.

## Timing
- Reset values:
  - state IDLE;
  - `req_valid`=0, `resp_ready`=0, `req_write`=0;
  - `req_addr`=0, `req_data`=0, `req_mask`=4'hf;
  - `rd_data`=0, `status`=0, `idle`=1, `done`=0.
- All outputs are registered or decoded from state; there is no combinational path from `cmd_*` or `req_ready` to any output.
- Command in cycle N gives `req_valid` in N+1.
- With `req_ready` tied high and a response in the cycle after acceptance, `done` is in N+3 and `idle` returns in N+4. `done` and the updated `rd_data`/`status` are visible in the same cycle.
- `resp_valid` in the same cycle the request is accepted is not taken: `resp_ready` is 0 in REQ.
- Timeout with TIMEOUT=4: `done` follows 4 WAIT cycles after acceptance.
- Asynchronous reset in mid-operation returns everything to the reset values immediately. A later stray response is not ready-accepted because `resp_ready` stays 0 in IDLE.

## Structure
- Package `dmi_pkg`:
  - `dmi_op_e` (NOP, READ, WRITE, RSVD);
  - `dmi_status_e` (SUCCESS=0, FAILED=2, BUSY=3);
  - `dmi_state_e`;
  - `DMI_ADDR_W`;
  - DM register addresses DMCONTROL=7'h10 and HAWINDOWSEL=7'h14.
- One sub-module, `dmi_timeout_ctr`: clear/enable counter with an `expired` output; TIMEOUT=0 ties `expired` to 0.
- Everything else lives in a single FSM module.

## Test plan
- **Write:** write addr 7'h10, data 32'h8000_0001; `req_ready`=1, response 1 cycle later with `resp_err`=0 → `req_write`=1, `req_data`=32'h8000_0001, `req_mask`=4'hf, `done` in N+3, `status`=0.
- **Read:** read addr 7'h10, response data 32'h0000_0003 → `rd_data`=32'h0000_0003, `status`=0; a subsequent write leaves `rd_data` unchanged.
- **Busy:** second read issued during WAIT → `status`=3 and one request only. After the response, further commands are ignored until a `dmi_reset` pulse, after which a read succeeds.
- **Timeout:** TIMEOUT=4, no response → `status`=2, `done` 4 cycles after acceptance, then DRAIN. A late response is consumed without changing `rd_data`, then IDLE.
- **Error response:** `resp_err`=1 on a read → `status`=2; `rd_data` equals `resp_data`.
- **Hard reset and async reset:**
  - `dmi_hard_reset` in REQ with `req_ready`=0 → IDLE, `req_valid`=0 next cycle, `status`=0.
  - Async `reset` asserted in WAIT → all outputs at reset values immediately; no hang afterwards.
